// File: rtl/rv_mem_pkg.sv
// ============================================================================
//  Module   : rv_mem_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader.
//             Optional checksum state is present when IMEM_LOADER_CHECKSUM_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] FULL_WE    = 4'hF;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CSUM  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// ============================================================================
//  Module   : byte_assembler
//  Purpose  : Collects four bytes little-endian into a 32-bit word and flags
//             the cycle the fourth byte is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic [31:0] word_full,
   output logic        word_ready
);

   logic [1:0]  cnt_q,   cnt_d;
   logic [31:0] shift_q, shift_d;

   // Shifting in from the top leaves the first byte in [7:0] after four bytes.
   always_comb begin
      word_full  = {byte_in, shift_q[31:8]};
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      word_ready = byte_en && (cnt_q == 2'd3);
      if (byte_en) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = word_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 2'd0;
         shift_q <= 32'd0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   assign word = shift_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Streams a length-prefixed byte image into BRAM port A and holds
//             the core in reset until the load completes.
//             Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
   import rv_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic [3:0]  wea,
   output logic [31:0] addra,
   output logic [31:0] dia,
   output logic        core_rst_n,
   output logic        done,
   output logic        err
);

   localparam int IDX_W = $clog2(MAX_WORDS + 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] n_q, n_d;
   logic             started_q;
   logic             byte_en;
   logic [31:0]      word, word_full;
   logic             word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   // Only header and payload bytes go through the assembler.
   assign byte_en = s_valid && s_ready &&
                    ((state_q == ST_LEN) || (state_q == ST_DATA));

   byte_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_en   (byte_en),
      .byte_in   (s_data),
      .word      (word),
      .word_full (word_full),
      .word_ready(word_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LEN;
         idx_q     <= '0;
         n_q       <= '0;
         started_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         started_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      n_d     = n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      if (byte_en && (state_q == ST_DATA)) csum_d = csum_q ^ s_data;
`endif
      case (state_q)
         ST_LEN: begin
            if (word_ready) begin
               if (word_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else if (word_full > 32'(MAX_WORDS)) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_DATA;
                  n_d     = word_full[IDX_W-1:0];
               end
            end
         end
         ST_DATA: begin
            if (word_ready) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            idx_d = idx_q + IDX_W'(1);
            if ((idx_q + IDX_W'(1)) < n_q) begin
               state_d = ST_DATA;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (s_valid && s_ready) state_d = (s_data == csum_q) ? ST_DONE : ST_ERROR;
         end
`endif
         default: state_d = state_q;
      endcase
   end

   // started_q keeps s_ready low while reset is held and until the first edge after.
   always_comb begin
      s_ready    = 1'b0;
      wea        = 4'h0;
      addra      = 32'd0;
      dia        = 32'd0;
      core_rst_n = (state_q == ST_DONE);
      done       = (state_q == ST_DONE);
      err        = (state_q == ST_ERROR);
      case (state_q)
         ST_LEN, ST_DATA: s_ready = started_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM:         s_ready = started_q;
`endif
         ST_WRITE: begin
            wea   = FULL_WE;
            addra = ADDR_BASE + 32'(idx_q) * 32'(WORD_BYTES);
            dia   = word;
         end
         default: s_ready = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected BRAM writes are queued by the
// stimulus process and popped by a monitor whenever wea is asserted.
`default_nettype none

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        s_ready;
   logic [3:0]  wea;
   logic [31:0] addra, dia;
   logic        core_rst_n, done, err;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [63:0] exp_q[$];

   imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .wea(wea), .addra(addra), .dia(dia),
      .core_rst_n(core_rst_n), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every write cycle must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && wea != 4'h0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {addra, dia}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("write_we", {60'd0, wea}, 64'hF);
            check("write_addr_data", {addra, dia}, e);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      s_valid = 1'b1;
      s_data  = b;
      t = 0;
      while (!s_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("handshake_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("reset_outputs", {27'd0, wea, addra, s_ready, core_rst_n, done, err},
            {27'd0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      check("reset_dia", {32'd0, dia}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("ready_low_before_edge", {63'd0, s_ready}, 64'd0);
      @(posedge clk); #1;
      check("ready_after_edge", {63'd0, s_ready}, 64'd1);
   endtask

   task automatic run_payload(input bit gap);
      send_word(32'd3, gap);
      exp_q.push_back({32'h0, 32'h0302_0100});
      exp_q.push_back({32'h4, 32'hA5A5_5A5A});
      exp_q.push_back({32'h8, 32'h0BAD_F00D});
      send_word(32'h0302_0100, gap);
      send_word(32'hA5A5_5A5A, gap);
      send_word(32'h0BAD_F00D, gap);
      repeat (3) @(posedge clk);
      #1;
      check("payload_done", {62'd0, done, core_rst_n}, 64'd3);
      check("payload_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      // Two-word example image.
      do_reset();
      exp_q.push_back({32'h0, 32'h1234_5678});
      exp_q.push_back({32'h4, 32'hDEAD_BEEF});
      send_word(32'd2, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("done_not_before_write", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      check("basic_done", {61'd0, done, core_rst_n, err}, 64'b110);
      check("basic_ready_low", {63'd0, s_ready}, 64'd0);
`endif
      check("basic_queue_empty", 64'(exp_q.size()), 64'd0);

`ifndef IMEM_LOADER_CHECKSUM_EN
      // Zero-length image finishes right after the header.
      do_reset();
      send_word(32'd0, 1'b0);
      check("zero_len_done", {61'd0, done, core_rst_n, err}, 64'b110);
`endif

      // Oversized length aborts.
      do_reset();
      send_word(32'd1025, 1'b0);
      check("overflow_err", {60'd0, err, s_ready, core_rst_n, done}, 64'b1000);
      s_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("overflow_terminal", {62'd0, err, s_ready}, 64'b10);

`ifndef IMEM_LOADER_CHECKSUM_EN
      // Same 3-word image with and without gaps in s_valid.
      do_reset();
      run_payload(1'b0);
      do_reset();
      run_payload(1'b1);
`endif

      // Reset in the middle of a load, then a fresh one-word image.
      do_reset();
      exp_q.push_back({32'h0, 32'h1111_2222});
      exp_q.push_back({32'h4, 32'h3333_4444});
      send_word(32'd3, 1'b0);
      send_word(32'h1111_2222, 1'b0);
      send_word(32'h3333_4444, 1'b0);
      @(posedge clk); #1;
      check("midload_queue_empty", 64'(exp_q.size()), 64'd0);
      do_reset();
      exp_q.push_back({32'h0, 32'hAABB_CCDD});
      send_word(32'd1, 1'b0);
      send_word(32'hAABB_CCDD, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1'b0);
`else
      @(posedge clk); #1;
`endif
      check("restart_done", {62'd0, done, core_rst_n}, 64'd3);
      check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch.
      do_reset();
      exp_q.push_back({32'h0, 32'h0403_0201});
      send_word(32'd1, 1'b0);
      send_word(32'h0403_0201, 1'b0);
      send_byte(8'h04, 1'b0);
      check("csum_ok", {62'd0, done, err}, 64'b10);
      do_reset();
      exp_q.push_back({32'h0, 32'h0403_0201});
      send_word(32'd1, 1'b0);
      send_word(32'h0403_0201, 1'b0);
      send_byte(8'h05, 1'b0);
      check("csum_bad", {62'd0, done, err}, 64'b01);
      check("csum_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
